// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive sampler and its byte FIFO.
package uart_rx_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CD_W           = 13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Line configuration, captured while idle and held for the whole frame.
  typedef struct packed {
    logic [CD_W-1:0] cd;
    logic            par_en;
    logic            par_odd;
  } rx_cfg_t;

  // Terminal count of the tick divider; a divisor of 0 acts as 1.
  function automatic logic [CD_W-1:0] cd_last(input logic [CD_W-1:0] cd);
    return (cd == '0) ? '0 : cd - CD_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte FIFO: push/pop in one cycle, head shown combinationally (zero when empty).
// Push while full succeeds only together with a pop; otherwise it is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: 2-flop synchronizer, oversampled mid-bit sampling, parity/stop checks, byte FIFO.
// Byte visible 2 cycles after the stop mid-bit; if the FIFO is full and not popped that cycle it is dropped (overrun).
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 uart_rxd_i,
  input  logic [CD_W-1:0]      cd_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 rx_ready_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 rx_busy_o
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS + 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  rx_cfg_t              cfg_q, cfg_d;
  logic [CD_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] push_dat_q, push_dat_d;
  logic                 par_bit_q, par_bit_d;
  logic                 wait_high_q, wait_high_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rxd_meta_q, rxd_meta_d;
  logic                 rxd_sync_q, rxd_sync_d;
  logic                 tick;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  assign tick       = (state_q != ST_IDLE) && (tick_cnt_q == cd_last(cfg_q.cd));
  assign rx_valid_o = !fifo_empty;
  assign pop        = rx_valid_o && rx_ready_i;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + CD_W'(1);
    os_cnt_d     = tick ? os_cnt_q + OS_W'(1) : os_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    wait_high_d  = wait_high_q;
    push_d       = 1'b0;
    push_dat_d   = push_dat_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    rxd_meta_d   = uart_rxd_i;
    rxd_sync_d   = rxd_meta_q;
    overrun_d    = push_q && fifo_full && !pop;

    case (state_q)
      ST_IDLE: begin
        cfg_d.cd      = cd_i;
        cfg_d.par_en  = parity_en_i;
        cfg_d.par_odd = parity_odd_i;
        tick_cnt_d    = '0;
        os_cnt_d      = '0;
        bit_idx_d     = '0;
        // After reset or a framing error, a low line is not a start until it has been high.
        if (rxd_sync_q)        wait_high_d = 1'b0;
        else if (!wait_high_q) state_d     = ST_START;
      end
      ST_START: begin
        if (tick && os_cnt_q == OS_MID) begin
          os_cnt_d = '0;
          state_d  = rxd_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && os_cnt_q == OS_LAST) begin
          os_cnt_d  = '0;
          shreg_d   = {rxd_sync_q, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BI_W'(1);
          if (bit_idx_q == BI_LAST) state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick && os_cnt_q == OS_LAST) begin
          os_cnt_d  = '0;
          par_bit_d = rxd_sync_q;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          state_d  = ST_IDLE;
          if (!rxd_sync_q) begin
            frame_err_d = 1'b1;
            wait_high_d = 1'b1;
          end else if (cfg_q.par_en && (par_bit_q != ((^shreg_q) ^ cfg_q.par_odd))) begin
            parity_err_d = 1'b1;
          end else begin
            push_d     = 1'b1;
            push_dat_d = shreg_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      tick_cnt_q   <= '0;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      push_dat_q   <= '0;
      par_bit_q    <= 1'b0;
      wait_high_q  <= 1'b1;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      tick_cnt_q   <= tick_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      push_dat_q   <= push_dat_d;
      par_bit_q    <= par_bit_d;
      wait_high_q  <= wait_high_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push_q),
    .push_dat_i (push_dat_q),
    .pop_i      (pop),
    .head_dat_o (rx_data_o),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;
  assign rx_busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frame table plus glitch, overrun, push/pop-while-full and reset sequences.
module tb_uart_rx_sampler;

  logic        clk_i        = 1'b0;
  logic        rst_ni       = 1'b0;
  logic        uart_rxd_i   = 1'b1;
  logic [12:0] cd_i         = 13'd4;
  logic        parity_en_i  = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        rx_ready_i   = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        frame_err_o;
  logic        parity_err_o;
  logic        overrun_o;
  logic        rx_busy_o;

  uart_rx_sampler dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .uart_rxd_i   (uart_rxd_i),
    .cd_i         (cd_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o),
    .rx_busy_o    (rx_busy_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct {
    logic [12:0] cd;
    bit          pen;
    bit          podd;
    logic [7:0]  d;
    bit          pb;
    bit          sb;
    bit          push;
    bit          ferr;
    bit          perr;
  } vec_t;

  localparam int NV = 10;
  localparam int BC4 = 64;  // clock cycles per bit at cd_i = 4

  vec_t       vecs [NV];
  int         total = 0;
  int         bad = 0;
  int         ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, busy_rise_cnt = 0;
  int         cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int         f0, p0, o0, b0, wn, lat;
  logic       prev_busy = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] bv;

  always @(negedge clk_i) begin
    cyc++;
    if (frame_err_o)  ferr_cnt++;
    if (parity_err_o) perr_cnt++;
    if (overrun_o)    ovr_cnt++;
    if (!prev_busy && rx_busy_o) busy_rise_cnt++;
    if (prev_busy && !rx_busy_o) fall_cyc = cyc;
    if (!prev_valid && rx_valid_o) rise_cyc = cyc;
    prev_busy  = rx_busy_o;
    prev_valid = rx_valid_o;
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int bc_of(input logic [12:0] cd);
    return ((cd == 13'd0) ? 1 : int'(cd)) * 16;
  endfunction

  task automatic drive_bit(input logic v, input int n);
    uart_rxd_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pb, input bit sb, input int bc);
    @(posedge clk_i);
    #1;
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    if (pen) drive_bit(pb, bc);
    drive_bit(sb, bc);
    drive_bit(1'b1, 2 * bc);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    @(negedge clk_i);
    check({name, "_valid"}, int'(rx_valid_o), 1);
    check({name, "_data"}, int'(rx_data_o), int'(exp));
    rx_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_ready_i = 1'b0;
  endtask

  initial begin
    //            cd     pen   podd  data   pb    sb    push  ferr  perr
    vecs[0] = '{13'd27, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{13'd4,  1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{13'd4,  1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{13'd4,  1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{13'd4,  1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{13'd4,  1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{13'd4,  1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{13'd4,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{13'd0,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{13'd1,  1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", int'(rx_valid_o), 0);
    check("rst_data", int'(rx_data_o), 0);
    check("rst_busy", int'(rx_busy_o), 0);
    check("rst_ferr", int'(frame_err_o), 0);
    check("rst_perr", int'(parity_err_o), 0);
    check("rst_ovr", int'(overrun_o), 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    for (int i = 0; i < NV; i++) begin
      cd_i         = vecs[i].cd;
      parity_en_i  = vecs[i].pen;
      parity_odd_i = vecs[i].podd;
      f0 = ferr_cnt;
      p0 = perr_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].d, vecs[i].pen, vecs[i].pb, vecs[i].sb, bc_of(vecs[i].cd));
      check($sformatf("v%0d_valid", i), int'(rx_valid_o), int'(vecs[i].push));
      check($sformatf("v%0d_ferr", i), ferr_cnt - f0, int'(vecs[i].ferr));
      check($sformatf("v%0d_perr", i), perr_cnt - p0, int'(vecs[i].perr));
      check($sformatf("v%0d_ovr", i), ovr_cnt - o0, 0);
      if (vecs[i].push) begin
        // Valid must follow the stop-sample return to IDLE by 1..2 cycles.
        lat = rise_cyc - fall_cyc;
        check($sformatf("v%0d_lat%0d_in_1_2", i, lat), int'(lat >= 1 && lat <= 2), 1);
        pop_check($sformatf("v%0d_pop", i), vecs[i].d);
      end
    end

    // Quarter-bit glitch on the idle line.
    cd_i = 13'd4;
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;
    b0 = busy_rise_cnt; f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
    @(posedge clk_i);
    #1;
    drive_bit(1'b0, BC4 / 4);
    drive_bit(1'b1, 200);
    check("glitch_busy_rise", busy_rise_cnt - b0, 1);
    check("glitch_busy", int'(rx_busy_o), 0);
    check("glitch_valid", int'(rx_valid_o), 0);
    check("glitch_errs", (ferr_cnt - f0) + (perr_cnt - p0) + (ovr_cnt - o0), 0);

    // Overrun: five bytes into a four-deep FIFO with no consumer.
    for (int k = 1; k <= 5; k++) begin
      bv = 8'(k);
      o0 = ovr_cnt;
      send_frame(bv, 1'b0, 1'b0, 1'b1, BC4);
      check($sformatf("ovr_frame%0d", k), ovr_cnt - o0, (k == 5) ? 1 : 0);
    end
    for (int k = 1; k <= 4; k++) begin
      bv = 8'(k);
      pop_check($sformatf("ovr_pop%0d", k), bv);
    end
    @(negedge clk_i);
    check("ovr_empty", int'(rx_valid_o), 0);

    // Push and pop in the same cycle while full.
    for (int k = 0; k < 4; k++) begin
      bv = 8'h11 + 8'(k);
      send_frame(bv, 1'b0, 1'b0, 1'b1, BC4);
    end
    o0 = ovr_cnt;
    wn = 0;
    fork
      send_frame(8'h15, 1'b0, 1'b0, 1'b1, BC4);
      begin
        while (!rx_busy_o && wn < 20000) begin @(negedge clk_i); wn++; end
        while (rx_busy_o && wn < 20000) begin @(negedge clk_i); wn++; end
        rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rx_ready_i = 1'b0;
      end
    join
    check("pp_wait_in_budget", int'(wn < 20000), 1);
    check("pp_ovr", ovr_cnt - o0, 0);
    for (int k = 2; k <= 5; k++) begin
      bv = 8'h10 + 8'(k);
      pop_check($sformatf("pp_pop%0d", k), bv);
    end
    @(negedge clk_i);
    check("pp_empty", int'(rx_valid_o), 0);

    // Reset in the middle of data bit 3, with a byte already queued.
    send_frame(8'h99, 1'b0, 1'b0, 1'b1, BC4);
    check("pre_rst_valid", int'(rx_valid_o), 1);
    fork
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1, BC4);
      begin
        @(posedge clk_i);
        repeat (4 * BC4 + BC4 / 2) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        check("mid_rst_valid", int'(rx_valid_o), 0);
        check("mid_rst_data", int'(rx_data_o), 0);
        check("mid_rst_busy", int'(rx_busy_o), 0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
      end
    join
    // Bit 7 of the aborted frame is the next falling edge, so it starts a frame of all ones.
    repeat (12 * BC4) @(posedge clk_i);
    #1;
    pop_check("post_rst_tail", 8'hFF);
    f0 = ferr_cnt;
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, BC4);
    pop_check("post_rst_7e", 8'h7E);
    check("post_rst_ferr", ferr_cnt - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-002 Parameter OVERSAMPLE, default 16: sample ticks per bit.
REQ-003 Parameter FIFO_DEPTH, default 4: received-byte buffer depth, power of two.
REQ-004 clk_i  input  1  system clock (50 MHz); the block SHALL use one clock only.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 uart_rxd_i  input  1  raw asynchronous serial line, idle high.
REQ-007 cd_i  input  13  clock divisor; one sample tick every cd_i clk_i cycles.
REQ-008 parity_en_i  input  1  1 = frame carries one parity bit after the data bits.
REQ-009 parity_odd_i  input  1  1 = odd parity, 0 = even parity.
REQ-010 rx_ready_i  input  1  consumer accepts the head byte this cycle.
REQ-011 rx_data_o  output  DATA_BITS  FIFO head byte.
REQ-012 rx_valid_o  output  1  FIFO not empty.
REQ-013 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-014 parity_err_o  output  1  one-cycle pulse: parity mismatch.
REQ-015 overrun_o  output  1  one-cycle pulse: good byte dropped, FIFO full.
REQ-016 rx_busy_o  output  1  FSM not in IDLE.

Function
REQ-017 uart_rxd_i SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-018 Tick counter SHALL count 0..cd_i-1 and pulse sample_tick for one cycle at the wrap; cd_i = 0 SHALL behave as cd_i = 1; the counter restarts from 0 on the IDLE-to-START transition.
REQ-019 Bit counter SHALL count sample ticks 0..OVERSAMPLE-1 within each bit.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-021 IDLE: a synchronized low SHALL move the FSM to START.
REQ-022 START: at tick OVERSAMPLE/2-1, a high line SHALL return the FSM to IDLE with no error (glitch); a low line SHALL move it to DATA.
REQ-023 DATA: the line SHALL be sampled once every OVERSAMPLE ticks (mid-bit) and shifted in LSB first; after DATA_BITS samples the FSM SHALL go to PARITY if parity_en_i, else to STOP.
REQ-024 PARITY: the bit SHALL be sampled mid-bit and compared with XOR(data) ^ parity_odd_i; expected value = XOR of data for even parity, its inverse for odd.
REQ-025 STOP: the bit SHALL be sampled mid-bit, then the FSM SHALL return to IDLE in the same cycle, with no half-bit wait.
REQ-026 Stop low: frame_err_o SHALL pulse, the byte SHALL be discarded, and the FSM SHALL return to IDLE and wait for the line high before a new start is recognised.
REQ-027 Stop high with parity error: parity_err_o SHALL pulse and the byte SHALL be discarded; frame error takes precedence over parity error.
REQ-028 Good byte: it SHALL be pushed on the clk_i edge following the stop sample, and rx_valid_o SHALL rise one cycle later when the FIFO was empty.
REQ-029 FIFO full with no pop in the same cycle: the byte SHALL be dropped and overrun_o SHALL pulse.
REQ-030 Push and pop in the same cycle while full: both SHALL succeed and overrun_o SHALL stay low.
REQ-031 Pop SHALL occur when rx_valid_o && rx_ready_i; rx_data_o SHALL show the head byte combinationally and hold it stable while rx_valid_o && !rx_ready_i.
REQ-032 Changes to cd_i, parity_en_i or parity_odd_i mid-frame are unsupported; they SHALL be sampled only in IDLE.

Reset
REQ-033 On rst_ni low: FSM = IDLE, all counters = 0, FIFO empty, synchronizer = 1, rx_data_o = 0, rx_valid_o = 0, all error pulses = 0, rx_busy_o = 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; after release, reception SHALL start at the next falling edge.

Structure
REQ-035 Package uart_rx_pkg SHALL hold the FSM state enum and the defaults for DATA_BITS, OVERSAMPLE and FIFO_DEPTH.
REQ-036 The FIFO SHALL be the single sub-module uart_rx_fifo (push/pop/full/empty, pointers one bit wider than the address).

Verification
REQ-037 cd_i=27, 8N1 frame 0x55 at 115200 baud -> rx_data_o=0x55 and rx_valid_o=1 within 2 cycles of the stop mid-bit; no error pulses.
REQ-038 Even parity, frame 0xA3 with parity bit 1 -> byte not pushed, parity_err_o pulses once; with parity bit 0 -> 0xA3 delivered.
REQ-039 Stop bit held low, frame 0x0F -> frame_err_o pulses once, FIFO stays empty, next valid frame 0x12 delivered.
REQ-040 0.25-bit low glitch on idle line -> FSM returns to IDLE, rx_busy_o falls, no outputs change.
REQ-041 rx_ready_i=0, five frames 0x01..0x05 -> FIFO holds 0x01..0x04, overrun_o pulses on 0x05; the bench then pops 4 bytes in order.
REQ-042 rst_ni pulsed low in the middle of bit 3 -> all outputs at reset values; the following frame 0x7E is received correctly.
